// File: rtl/ham_pkg.sv
// Shared types and sizing helpers for the SECDED Hamming decoder.
package ham_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    CLEAN,
    CORR_DATA,
    CORR_PAR,
    UNCORR
  } err_class_e;

  // Smallest parity width p with 2^p >= data_w + p + 1.
  function automatic int par_w_f(input int data_w);
    int p_w;
    p_w = 1;
    for (int p = 1; p < 8; p++) begin
      if ((1 << p) < data_w + p + 1) p_w = p + 1;
    end
    return p_w;
  endfunction

endpackage

// File: rtl/ham_secded_core.sv
// Combinational SECDED syndrome, classification and single-bit correction.
module ham_secded_core
  import ham_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [DATA_W-1:0] data_o,
  output logic [PAR_W-1:0]  syn_o,
  output err_class_e        cls_o
);

  // Hamming position holding payload bit k (k-th non-power-of-two position).
  function automatic int data_pos_f(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic [CODE_W-1:0] fixed;
  logic [PAR_W-1:0]  syn;
  logic              pf;
  logic              flip;

  always_comb begin
    syn = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (code_i[p]) syn = syn ^ PAR_W'(p);
    end
    pf = ^code_i;

    flip  = 1'b0;
    cls_o = CLEAN;
    if (syn == '0) begin
      cls_o = pf ? CORR_PAR : CLEAN;
    end else if (!pf) begin
      cls_o = UNCORR;
    end else if (int'(syn) <= CODE_W - 1) begin
      cls_o = CORR_DATA;
      flip  = 1'b1;
    end else begin
      cls_o = UNCORR;
    end

    fixed = code_i;
    for (int p = 1; p < CODE_W; p++) begin
      fixed[p] = code_i[p] ^ (flip && (syn == PAR_W'(p)));
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    assign data_o[k] = fixed[data_pos_f(k)];
  end

  assign syn_o = syn;

endmodule

// File: rtl/ham_secded_decoder.sv
// SECDED decoder with a one-deep valid/ready output register.
// Error counters are built only when HAM_DEC_CNT_EN is defined.
module ham_secded_decoder
  import ham_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] enc_ham_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  pos_error,
  output logic              corrected,
  output logic              uncorrectable,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic [DATA_W-1:0] core_data;
  logic [PAR_W-1:0]  core_syn;
  err_class_e        core_cls;
  logic              accept;

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [PAR_W-1:0]  pos_q;
  logic              corr_q;
  logic              uncorr_q;

  ham_secded_core #(.DATA_W(DATA_W)) u_core (
    .code_i (enc_ham_data),
    .data_o (core_data),
    .syn_o  (core_syn),
    .cls_o  (core_cls)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Result fields load only on accept, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      pos_q    <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      data_q   <= core_data;
      pos_q    <= core_syn;
      corr_q   <= (core_cls == CORR_DATA) || (core_cls == CORR_PAR);
      uncorr_q <= (core_cls == UNCORR);
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign data          = data_q;
  assign pos_error     = pos_q;
  assign corrected     = corr_q;
  assign uncorrectable = uncorr_q;

`ifdef HAM_DEC_CNT_EN
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;
  logic             inc_corr, inc_uncorr;

  assign inc_corr   = accept && ((core_cls == CORR_DATA) || (core_cls == CORR_PAR));
  assign inc_uncorr = accept && (core_cls == UNCORR);

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else begin
      if (inc_corr && (cnt_corr_q != '1))     cnt_corr_d   = cnt_corr_q + 1'b1;
      if (inc_uncorr && (cnt_uncorr_q != '1)) cnt_uncorr_d = cnt_uncorr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_corr       = '0;
  assign cnt_uncorr     = '0;
`endif

endmodule

// File: tb/tb_ham_secded_decoder.sv
// Directed bench for ham_secded_decoder with DATA_W=4 (8-bit codewords).
module tb_ham_secded_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  enc_ham_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  data;
  logic [2:0]  pos_error;
  logic        corrected;
  logic        uncorrectable;
  logic        cnt_clr;
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;

  int checks   = 0;
  int failures = 0;

  ham_secded_decoder #(.DATA_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .enc_ham_data  (enc_ham_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data          (data),
    .pos_error     (pos_error),
    .corrected     (corrected),
    .uncorrectable (uncorrectable),
    .cnt_clr       (cnt_clr),
    .cnt_corr      (cnt_corr),
    .cnt_uncorr    (cnt_uncorr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                         input logic [2:0] p, input logic c, input logic u);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"}, 32'(data), 32'(d));
    chk({tag, ".pos_error"}, 32'(pos_error), 32'(p));
    chk({tag, ".corrected"}, 32'(corrected), 32'(c));
    chk({tag, ".uncorrectable"}, 32'(uncorrectable), 32'(u));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] c, input logic [15:0] u);
`ifdef HAM_DEC_CNT_EN
    chk({tag, ".cnt_corr"}, 32'(cnt_corr), 32'(c));
    chk({tag, ".cnt_uncorr"}, 32'(cnt_uncorr), 32'(u));
`else
    chk({tag, ".cnt_corr"}, 32'(cnt_corr), 32'(0));
    chk({tag, ".cnt_uncorr"}, 32'(cnt_uncorr), 32'(0));
    if (c === 16'hx || u === 16'hx) $display("note: unexpected X count request");
`endif
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    enc_ham_data = 8'h00;
    out_ready    = 1'b0;
    cnt_clr      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'(1));
    chk_cnt("reset", 16'd0, 16'd0);

    // Single words with the consumer always ready.
    out_ready = 1'b1;
    in_valid = 1'b1; enc_ham_data = 8'hAA; tick(); in_valid = 1'b0;
    chk_out("clean", 1'b1, 4'hB, 3'd0, 1'b0, 1'b0);
    tick();
    chk("clean.drain", 32'(out_valid), 32'(0));

    in_valid = 1'b1; enc_ham_data = 8'hEA; tick(); in_valid = 1'b0;
    chk_out("single", 1'b1, 4'hB, 3'd6, 1'b1, 1'b0);
    chk_cnt("single", 16'd1, 16'd0);

    in_valid = 1'b1; enc_ham_data = 8'hAB; tick(); in_valid = 1'b0;
    chk_out("parbit", 1'b1, 4'hB, 3'd0, 1'b1, 1'b0);

    in_valid = 1'b1; enc_ham_data = 8'hE2; tick(); in_valid = 1'b0;
    chk_out("double", 1'b1, 4'hE, 3'd5, 1'b0, 1'b1);
    chk_cnt("double", 16'd2, 16'd1);

    // Back-to-back with no bubble.
    in_valid = 1'b1; enc_ham_data = 8'hAA; tick();
    chk_out("b2b0", 1'b1, 4'hB, 3'd0, 1'b0, 1'b0);
    enc_ham_data = 8'hEA; tick(); in_valid = 1'b0;
    chk_out("b2b1", 1'b1, 4'hB, 3'd6, 1'b1, 1'b0);
    tick();
    chk("b2b.drain", 32'(out_valid), 32'(0));

    // Backpressure: three words, consumer stalled four cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; enc_ham_data = 8'hAA; tick();
    chk("bp.in_ready", 32'(in_ready), 32'(0));
    enc_ham_data = 8'hEA;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 4'hB, 3'd0, 1'b0, 1'b0);
      chk("bp.hold.in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(in_ready), 32'(1));
    tick();
    chk_out("bp.w2", 1'b1, 4'hB, 3'd6, 1'b1, 1'b0);
    enc_ham_data = 8'hE2; tick(); in_valid = 1'b0;
    chk_out("bp.w3", 1'b1, 4'hE, 3'd5, 1'b0, 1'b1);
    tick();
    chk("bp.drain", 32'(out_valid), 32'(0));
    chk_cnt("bp", 16'd4, 16'd2);

`ifdef HAM_DEC_CNT_EN
    force dut.cnt_corr_q = 16'hFFFF;
    #1;
    release dut.cnt_corr_q;
`endif
    in_valid = 1'b1; enc_ham_data = 8'hEA; tick(); in_valid = 1'b0;
    chk_out("sat", 1'b1, 4'hB, 3'd6, 1'b1, 1'b0);
    chk_cnt("sat", 16'hFFFF, 16'd2);

    cnt_clr = 1'b1; in_valid = 1'b1; enc_ham_data = 8'hE2; tick();
    cnt_clr = 1'b0; in_valid = 1'b0;
    chk_cnt("clr", 16'd0, 16'd0);
    tick();

    // Reset during a stall discards the held word and wins over new input.
    out_ready = 1'b0;
    in_valid = 1'b1; enc_ham_data = 8'hAB; tick();
    enc_ham_data = 8'hEA; tick();
    chk_out("rst.stall", 1'b1, 4'hB, 3'd0, 1'b1, 1'b0);
    rst = 1'b1; cnt_clr = 1'b1; tick();
    rst = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    chk_out("rst.mid", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("rst.in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1; tick();
    chk("rst.lost", 32'(out_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ham_secded_decoder.md
HAM_SECDED_DECODER -- requirements
Module: ham_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data payload width; legal range 4..57.
REQ-002 SHALL have derived localparam PAR_W, the smallest value with 2^PAR_W >= DATA_W+PAR_W+1; and CODE_W = DATA_W+PAR_W+1, the Hamming bits plus one overall-parity bit.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- enc_ham_data  in  CODE_W  received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- data  out  DATA_W  corrected payload.
- pos_error  out  PAR_W  syndrome; 0 means no Hamming-bit error.
- corrected  out  1  single error fixed.
- uncorrectable  out  1  double or invalid error.
- cnt_clr  in  1  clear the error counters.
- cnt_corr  out  16  corrected-event count.
- cnt_uncorr  out  16  uncorrectable-event count.

Function
REQ-004 Codeword layout SHALL be:
- enc_ham_data[0] is overall even parity over bits CODE_W-1..1.
- enc_ham_data[p] is Hamming position p, for p = 1..CODE_W-1.
- Check bits sit at power-of-two positions.
- Data bits fill the remaining positions in ascending order, with data[0] at the lowest position.
REQ-005 Syndrome SHALL be the XOR of the indices p (1..CODE_W-1) of all set bits; overall-parity fail (pf) SHALL be the XOR of all CODE_W bits.
REQ-006 Classification SHALL be:
- syn=0, pf=0: clean.
- syn!=0, pf=1, syn<=CODE_W-1: flip bit syn and assert corrected.
- syn=0, pf=1: the parity bit is in error; data unchanged; assert corrected.
- syn!=0, pf=0: assert uncorrectable and pass data uncorrected.
- syn>CODE_W-1, pf=1: assert uncorrectable.
REQ-007 A transfer SHALL occur on each edge where in_valid and in_ready are both 1.
REQ-008 Results SHALL be registered; latency is exactly 1 cycle from the accepting edge to out_valid=1.
REQ-009 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-010 Back-to-back transfers SHALL sustain 1 word per cycle.
REQ-011 While out_valid=1 and out_ready=0, data, pos_error, corrected and uncorrectable SHALL hold stable.
REQ-012 out_valid SHALL clear on an out_ready handshake when no new word is accepted on the same edge.
REQ-013 When a word is accepted on the same edge as an output handshake, the new result SHALL load; there is no bubble.
REQ-014 Counters SHALL increment by 1 on each accepted word of the matching class and SHALL saturate at 16'hFFFF.
REQ-015 cnt_clr SHALL set both counters to 0 and takes priority over a simultaneous increment.
REQ-016 corrected and uncorrectable SHALL never both be 1.

Reset
REQ-017 On rst=1 at an edge, the block SHALL set out_valid=0, data=0, pos_error=0, corrected=0, uncorrectable=0 and both counters to 0.
REQ-018 A word in flight when rst is asserted SHALL be discarded.
REQ-019 rst SHALL take priority over in_valid and cnt_clr.
REQ-020 in_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-021 The macro HAM_DEC_CNT_EN SHALL control the counters:
- Defined: the counters and cnt_clr logic of REQ-014 and REQ-015 are built.
- Undefined: cnt_corr and cnt_uncorr are tied to 0, cnt_clr is ignored, and no counter flops are built.
- Decode path behaviour is identical in both cases.

Structure
REQ-022 Package ham_pkg SHALL hold:
- the par_w_f(DATA_W) function;
- the err_class_e enum {CLEAN, CORR_DATA, CORR_PAR, UNCORR};
- the counter width constant CNT_W=16.
REQ-023 The combinational syndrome/correct logic SHALL be the sub-module ham_secded_core; the top level holds the handshake register and counters.

Verification
REQ-024 Clean word, DATA_W=4: enc=8'hAA -> one cycle later data=4'hB, pos_error=0, corrected=0, uncorrectable=0.
REQ-025 Single data-bit error: enc=8'hEA -> data=4'hB, pos_error=6, corrected=1, cnt_corr increments.
REQ-026 Parity-bit error: enc=8'hAB -> data=4'hB, pos_error=0, corrected=1.
REQ-027 Double error: enc=8'hE2 -> pos_error=5, uncorrectable=1, corrected=0, cnt_uncorr increments.
REQ-028 Backpressure: 3 back-to-back words with out_ready=0 for 4 cycles:
- in_ready=0 after the first word is held;
- outputs stay stable while stalled;
- all 3 results then emerge in order with no drop or duplicate.
REQ-029 Saturation/clear and reset:
- Force cnt_corr to FFFF, then a corrected word -> cnt_corr stays FFFF.
- cnt_clr together with an error word -> cnt_corr=0.
- rst mid-stall -> out_valid=0 and the held word is lost.
